// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl
//   Sequencer for the Ascon round datapath (Pc -> Ps -> Pl, one round per
//   cycle). Runs p^a (ROUNDS_A rounds) or p^b (ROUNDS_B rounds) on request.
//   It produces the round index and round constant, the input-mux select and
//   the 320-bit state-register enable.
//
// Ports
//   clock_i     in   1      system clock, rising edge
//   resetb_i    in   1      asynchronous active-low reset
//   start_i     in   1      request a permutation (sampled only in IDLE)
//   sel_pa_i    in   1      1: p^a, 0: p^b (sampled together with start_i)
//   stall_i     in   1      freeze the running permutation this cycle
//   round_o     out  CNT_W  current round index
//   const_o     out  8      round constant {4'hF - i, i} for Pc
//   sel_init_o  out  1      1: datapath input is the external state
//   en_state_o  out  1      state-register load enable
//   busy_o      out  1      permutation in progress (RUN or DONE)
//   done_o      out  1      one-cycle pulse, state register holds the result
module ascon_perm_ctrl #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6,
    parameter int CNT_W    = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             sel_pa_i,
    input  logic             stall_i,
    output logic [CNT_W-1:0] round_o,
    output logic [7:0]       const_o,
    output logic             sel_init_o,
    output logic             en_state_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Both permutations end on the same round index, so p^b simply starts
    // further along the counter.
    localparam logic [CNT_W-1:0] START_A = CNT_W'(0);
    localparam logic [CNT_W-1:0] START_B = CNT_W'(ROUNDS_A - ROUNDS_B);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(ROUNDS_A - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             first, first_nxt;
    logic [3:0]       idx;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state <= IDLE;
            cnt   <= '0;
            first <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            first <= first_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        first_nxt  = first;
        sel_init_o = 1'b0;
        en_state_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                    cnt_nxt   = sel_pa_i ? START_A : START_B;
                    first_nxt = 1'b1;
                end
            end
            RUN: begin
                busy_o     = 1'b1;
                // The first round loads from the external state; later rounds
                // feed back the state register.
                sel_init_o = first;
                en_state_o = ~stall_i;
                if (!stall_i) begin
                    if (cnt == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt + CNT_W'(1);
                        first_nxt = 1'b0;
                    end
                end
            end
            DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = IDLE;
                // Return the counter to 0 so IDLE always shows i=0.
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign idx     = 4'(cnt);
    assign round_o = cnt;
    assign const_o = {4'hF - idx, idx};

endmodule
